// File: rtl/rom_port_responder.sv
// rom_port_responder
//   Responder end of a toggle-handshake memory port. A request is pending while
//   the synchronised port_req differs from port_ack. The request is latched and
//   issued as a single valid/ready command. Reads then wait for the returned
//   word. A one-word read cache lets repeated reads of the same word complete
//   without a memory access.
// Ports:
//   clk_sys, res_n            clock, asynchronous active-low reset
//   port_req / port_ack       request / acknowledge toggles
//   port_a, port_ds, port_we  word address, byte strobes, write flag
//   port_d / port_q           write data / read data (valid at ack toggle)
//   mem_valid, mem_ready      command handshake
//   mem_we, mem_a, mem_be,
//   mem_d                     command fields (stable while mem_valid)
//   mem_rvalid, mem_rdata     one-cycle read-data return
//   timeout_err               sticky: a read timed out waiting for data
module rom_port_responder #(
  parameter int unsigned AW      = 23,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk_sys,
  input  logic              res_n,
  input  logic              port_req,
  output logic              port_ack,
  input  logic [AW-1:0]     port_a,
  input  logic [DW/8-1:0]   port_ds,
  input  logic              port_we,
  input  logic [DW-1:0]     port_d,
  output logic [DW-1:0]     port_q,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_a,
  output logic [DW/8-1:0]   mem_be,
  output logic [DW-1:0]     mem_d,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,
  output logic              timeout_err
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_req_s1, r_req_s2;
  logic            r_ack;
  logic [DW-1:0]   r_q;
  logic [AW-1:0]   r_a;
  logic [BW-1:0]   r_ds;
  logic            r_we;
  logic [DW-1:0]   r_d;
  logic [CW-1:0]   r_cnt;
  logic            r_c_valid;
  logic [AW-1:0]   r_c_addr;
  logic [DW-1:0]   r_c_data;
  logic            r_terr;

  logic            w_req_pend;
  logic            w_hit_in;
  logic            w_latch;
  logic            w_hit_load;
  logic            w_accept;
  logic            w_rd_load;
  logic            w_to_load;
  logic            w_wr_hit;

  assign w_req_pend = r_req_s2 ^ r_ack;
  // Hit is decided on the live inputs, since the fields are latched this same cycle.
  assign w_hit_in   = r_c_valid && !port_we && (port_a == r_c_addr);
  assign w_wr_hit   = r_we && r_c_valid && (r_a == r_c_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_hit_load  = 1'b0;
    w_accept    = 1'b0;
    w_rd_load   = 1'b0;
    w_to_load   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req_pend) begin
          w_latch = 1'b1;
          if (w_hit_in) begin
            w_hit_load  = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StIssue;
          end
        end
      end
      StIssue: begin
        if (mem_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = r_we ? StDone : StWaitRd;
        end
      end
      StWaitRd: begin
        if (mem_rvalid) begin
          w_rd_load   = 1'b1;
          w_state_nxt = StDone;
        end else if (r_cnt == CntLast) begin
          w_to_load   = 1'b1;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      r_state   <= StIdle;
      r_req_s1  <= 1'b0;
      r_req_s2  <= 1'b0;
      r_ack     <= 1'b0;
      r_q       <= '0;
      r_a       <= '0;
      r_ds      <= '0;
      r_we      <= 1'b0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_c_valid <= 1'b0;
      r_c_addr  <= '0;
      r_c_data  <= '0;
      r_terr    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_req_s1 <= port_req;
      r_req_s2 <= r_req_s1;

      if (w_latch) begin
        r_a  <= port_a;
        r_ds <= port_ds;
        r_we <= port_we;
        r_d  <= port_d;
      end

      if (w_hit_load) begin
        r_q <= r_c_data;
      end

      if (w_accept) begin
        r_cnt <= '0;
        // Keep the cached word coherent with writes to the same address.
        if (w_wr_hit) begin
          for (int b = 0; b < int'(BW); b++) begin
            if (r_ds[b]) begin
              r_c_data[8*b +: 8] <= r_d[8*b +: 8];
            end
          end
        end
      end

      if (r_state == StWaitRd) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_rd_load) begin
        r_q       <= mem_rdata;
        r_c_addr  <= r_a;
        r_c_data  <= mem_rdata;
        r_c_valid <= 1'b1;
      end

      if (w_to_load) begin
        r_q    <= '1;
        r_terr <= 1'b1;
      end

      if (r_state == StDone) begin
        r_ack <= ~r_ack;
      end
    end
  end

  assign port_ack    = r_ack;
  assign port_q      = r_q;
  assign mem_valid   = (r_state == StIssue);
  assign mem_we      = r_we;
  assign mem_a       = r_a;
  assign mem_be      = r_ds;
  assign mem_d       = r_d;
  assign timeout_err = r_terr;

endmodule

// File: doc/rom_port_responder.md
Name: rom_port_responder

Overview:
- Responder end of the toggle-handshake memory port. Initiators flip port_req to post a request, and the block flips port_ack when that request completes.
- Latches the request (address, byte strobes, write flag, data) and issues one command on a simple valid/ready memory-command bus. On reads it waits for the returned word.
- Keeps a one-word read cache so that repeated reads of the same word finish without a memory access.
- Sits between the ROM download controller / CPU fetch logic and the SDRAM core in the MiST arcade tops.

Parameters:
- AW, 23, word address width.
- DW, 16, data width; byte strobes are DW/8 wide.
- TIMEOUT, 1023, maximum cycles to wait for read data before forcing completion.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- res_n  in  1  asynchronous active-low reset.
- port_req  in  1  request toggle; a request is pending while port_req != port_ack.
- port_ack  out  1  acknowledge toggle.
- port_a  in  AW  word address.
- port_ds  in  DW/8  byte strobes (bit1 = high byte).
- port_we  in  1  1 = write, 0 = read.
- port_d  in  DW  write data.
- port_q  out  DW  read data, valid when port_ack toggles for a read.
- mem_valid  out  1  command valid.
- mem_ready  in  1  command accepted when mem_valid & mem_ready.
- mem_we  out  1  command is a write.
- mem_a  out  AW  command address.
- mem_be  out  DW/8  byte enables.
- mem_d  out  DW  write data.
- mem_rvalid  in  1  one-cycle read-data strobe.
- mem_rdata  in  DW  read data.
- timeout_err  out  1  sticky flag: a read timed out.

Behaviour:
- Reset (res_n low, asynchronous):
  - port_ack = 0, port_q = 0, mem_valid = 0, mem_we = 0, mem_a = 0, mem_be = 0, mem_d = 0, timeout_err = 0.
  - Cache invalid; state IDLE.
- Reset mid-operation aborts the request without toggling ack. The initiator re-posts after reset.
- Synchronise port_req with two flops before use. A request is detected when req_sync != port_ack.
- Latching: port_a/ds/we/d are captured on the cycle the request is detected. The inputs must be stable from the req toggle until the ack toggle.
- State IDLE: on a detected request, latch the fields.
  - Read that hits the cache (cache valid and latched address == cached address): port_q <= cached word; go to DONE. No mem_valid is asserted.
  - Any other request: go to ISSUE.
- State ISSUE: drive mem_valid = 1 with the latched fields; mem_be = latched ds.
  - Hold mem_valid and all mem_* outputs stable until mem_ready.
  - On accept: a write goes to DONE; a read goes to WAIT_RD and clears the timeout counter.
- State WAIT_RD: the counter increments each cycle.
  - On mem_rvalid: port_q <= mem_rdata; cache <= {addr, mem_rdata, valid}; go to DONE.
  - If the counter reaches TIMEOUT without mem_rvalid: port_q <= all ones; set timeout_err; go to DONE.
  - A mem_rvalid that arrives in any other state is ignored.
- State DONE: port_ack <= ~port_ack (a single toggle); return to IDLE.
  - Minimum latency from the synchronised req to the ack toggle is 2 cycles for a cache hit and 3 cycles for a write with immediate ready.
- Cache coherence on writes to the cached address:
  - Update each cached byte whose ds bit is set with the port_d byte at the moment of accept.
  - A write with ds = 0 still issues a command (mem_be = 0) and leaves the cache unchanged.
- Only one request is outstanding at a time. A new toggle that arrives while busy is not lost: req_sync != port_ack stays true after DONE and is served next.
- Address width: mem_a = latched address unmodified. No wrap logic is needed.
- timeout_err is cleared only by reset.

Test Plan:
- Write: port_a = 0x000010, ds = 2'b01, d = 0x00AB, ready held high → one mem_valid cycle with be = 01, d = 0x00AB; port_ack toggles 0→1 within 5 cycles of the req toggle.
- Read miss then hit:
  - First read of 0x000020 with mem_rdata = 0x1234 after 3 cycles → port_q = 0x1234, ack toggles.
  - Repeat read → port_q = 0x1234, no mem_valid, ack toggles again.
- Backpressure: mem_ready held low for 10 cycles → mem_valid and mem_a/be/d are stable for all 10 cycles; exactly one accept; exactly one ack toggle.
- Coherence:
  - Cache 0x000020 = 0x1234, then write ds = 10, d = 0xCD00 to the same address.
  - A following read hits and returns 0xCD34 with no memory read.
- Timeout: a read with mem_rvalid never asserted → after TIMEOUT cycles port_q = 0xFFFF, timeout_err = 1, ack toggles; the next request is still serviced normally.
- Reset mid-read: assert res_n low while in WAIT_RD → all outputs return to reset values immediately, port_ack = 0, cache invalid, timeout_err = 0.
